// File: rtl/imem_fetch.sv
// imem_fetch: fetch stage for the X/Y-addressed instruction memory.
// Issues credit-checked reads, absorbs 1-cycle read latency, buffers words.
module imem_fetch #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter logic [2*ADDR_BITS-1:0] RESET_PC = '0
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic                   Fetch_en,
  output logic [ADDR_BITS-1:0]   X_addr,
  output logic [ADDR_BITS-1:0]   Y_addr,
  input  logic [DATA_WIDTH-1:0]  Data_out,
  input  logic                   Redirect,
  input  logic [2*ADDR_BITS-1:0] Redirect_pc,
  output logic                   Instr_valid,
  output logic [DATA_WIDTH-1:0]  Instr,
  output logic [2*ADDR_BITS-1:0] Instr_pc,
  input  logic                   Instr_ready
);

  localparam int PCW  = 2 * ADDR_BITS;
  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int CRW  = CNTW + 1;
  localparam logic [PTRW-1:0] LAST = PTRW'(FIFO_DEPTH - 1);
  localparam logic [CRW-1:0] DEPTH_C = CRW'(FIFO_DEPTH);

  logic [PCW-1:0]        r_pc;
  logic [PCW-1:0]        r_tag;
  logic                  r_inflight;
  logic                  r_discard;
  logic [DATA_WIDTH-1:0] r_data [FIFO_DEPTH];
  logic [PCW-1:0]        r_ipc  [FIFO_DEPTH];
  logic [PTRW-1:0]       r_rd;
  logic [PTRW-1:0]       r_wr;
  logic [CNTW-1:0]       r_count;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [CRW-1:0]        w_credit;

  function automatic logic [PTRW-1:0] f_next(input logic [PTRW-1:0] p);
    return (p == LAST) ? '0 : p + PTRW'(1);
  endfunction

  assign X_addr = r_pc[PCW-1:ADDR_BITS];
  assign Y_addr = r_pc[ADDR_BITS-1:0];

  assign Instr_valid = (r_count != '0);
  assign Instr       = Instr_valid ? r_data[r_rd] : '0;
  assign Instr_pc    = Instr_valid ? r_ipc[r_rd] : '0;

  assign w_pop = Instr_valid & Instr_ready & ~Redirect;

  // Slots already promised: buffered words plus the read still returning.
  assign w_credit = CRW'(r_count) + CRW'(r_inflight) - CRW'(w_pop);
  assign w_issue  = Fetch_en & ~Redirect & (w_credit < DEPTH_C);
  assign w_push   = r_inflight & ~r_discard & ~Redirect;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc       <= RESET_PC;
      r_tag      <= '0;
      r_inflight <= 1'b0;
      r_discard  <= 1'b0;
    end else if (Redirect) begin
      r_pc       <= Redirect_pc;
      r_discard  <= r_inflight;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_discard  <= 1'b0;
      if (w_issue) begin
        r_pc  <= r_pc + PCW'(1);
        r_tag <= r_pc;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_data[r_wr] <= Data_out;
      r_ipc[r_wr]  <= r_tag;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (Redirect) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= f_next(r_wr);
      if (w_pop)  r_rd <= f_next(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: directed and randomized checks of imem_fetch against
// an in-order stream scoreboard and a registered-read imem model.
module tb_imem_fetch;

  logic       clk;
  logic       rst_n;
  logic       fe;
  logic [3:0] xa;
  logic [3:0] ya;
  logic [31:0] dout;
  logic       redir;
  logic [7:0] rpc;
  logic       ivld;
  logic [31:0] instr;
  logic [7:0] ipc;
  logic       rdy;

  int checks = 0;
  int errors = 0;

  imem_fetch #(
    .ADDR_BITS(4),
    .DATA_WIDTH(32),
    .FIFO_DEPTH(2),
    .RESET_PC(8'h00)
  ) dut (
    .Clock(clk),
    .Reset_n(rst_n),
    .Fetch_en(fe),
    .X_addr(xa),
    .Y_addr(ya),
    .Data_out(dout),
    .Redirect(redir),
    .Redirect_pc(rpc),
    .Instr_valid(ivld),
    .Instr(instr),
    .Instr_pc(ipc),
    .Instr_ready(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'(a[7:4]) * 32'h100 + 32'(a[3:0]);
  endfunction

  always @(posedge clk) dout <= mem_word({xa, ya});

  // Stream scoreboard: accepted words must follow the PC sequence.
  logic [7:0]  exp_pc = 8'h00;
  logic        red1 = 1'b0;
  logic        red2 = 1'b0;
  logic        prv_hold = 1'b0;
  logic [7:0]  prv_pc = 8'h00;
  logic [31:0] prv_instr = 32'h0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      exp_pc = 8'h00;
      red1 = 1'b0;
      red2 = 1'b0;
      prv_hold = 1'b0;
    end else begin
      if (red1 || red2) begin
        checks++;
        if (ivld !== 1'b0) begin
          errors++;
          $display("FAIL flush_gap: valid=%b want 0", ivld);
        end
      end
      if (prv_hold) begin
        checks++;
        if (ivld !== 1'b1 || ipc !== prv_pc || instr !== prv_instr) begin
          errors++;
          $display("FAIL head_stable: v=%b pc=%h ins=%h want pc=%h ins=%h",
                   ivld, ipc, instr, prv_pc, prv_instr);
        end
      end
      if (redir) begin
        exp_pc = rpc;
      end else if (ivld && rdy) begin
        checks++;
        if (ipc !== exp_pc || instr !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL sb_order: pc=%h ins=%h want pc=%h ins=%h",
                   ipc, instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 8'd1;
      end
      red2 = red1;
      red1 = redir;
      prv_hold = ivld && !rdy && !redir;
      prv_pc = ipc;
      prv_instr = instr;
    end
  end

  task automatic step(input logic f, input logic r,
                      input logic rd, input logic [7:0] p);
    @(negedge clk);
    fe = f;
    rdy = r;
    redir = rd;
    rpc = p;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    fe = 1'b0;
    rdy = 1'b0;
    redir = 1'b0;
    rpc = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ivld !== 1'b0 || instr !== 32'h0 || ipc !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: v=%b ins=%h pc=%h want 0", ivld, instr, ipc);
    end
    checks++;
    if ({xa, ya} !== 8'h00) begin
      errors++;
      $display("FAIL reset_xy: xy=%h want 00", {xa, ya});
    end
  endtask

  task automatic release_stream;
    @(negedge clk);
    rst_n = 1'b1;
    fe = 1'b1;
    rdy = 1'b1;
    redir = 1'b0;
    #1;
    checks++;
    if (ivld !== 1'b0) begin
      errors++;
      $display("FAIL c0_valid: v=%b want 0", ivld);
    end
    step(1, 1, 0, 0);
    checks++;
    if (ivld !== 1'b0) begin
      errors++;
      $display("FAIL c1_valid: v=%b want 0", ivld);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      checks++;
      if (ivld !== 1'b1 || ipc !== 8'(i) || instr !== mem_word(8'(i))) begin
        errors++;
        $display("FAIL stream_%0d: v=%b pc=%h ins=%h want pc=%h",
                 i, ivld, ipc, instr, 8'(i));
      end
    end
  endtask

  task automatic test_stream;
    release_stream();
  endtask

  task automatic test_backpressure;
    logic [7:0] h;
    repeat (2) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    h = ipc;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step(1, 0, 0, 0);
      checks++;
      if (ivld !== 1'b1 || ipc !== h || {xa, ya} !== h + 8'd2) begin
        errors++;
        $display("FAIL stall_%0d: v=%b pc=%h xy=%h want pc=%h xy=%h",
                 i, ivld, ipc, {xa, ya}, h, h + 8'd2);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      checks++;
      if (ivld !== 1'b1 || ipc !== h + 8'(i)) begin
        errors++;
        $display("FAIL resume_%0d: v=%b pc=%h want %h", i, ivld, ipc, h + 8'(i));
      end
    end
  endtask

  task automatic test_redirect;
    step(1, 1, 1, 8'h05);
    repeat (2) step(1, 1, 0, 0);
    step(1, 1, 1, 8'h35);
    checks++;
    if (ivld !== 1'b1 || ipc !== 8'h05 || {xa, ya} !== 8'h07) begin
      errors++;
      $display("FAIL redir_pre: v=%b pc=%h xy=%h want pc=05 xy=07",
               ivld, ipc, {xa, ya});
    end
    step(1, 1, 0, 0);
    checks++;
    if (xa !== 4'h3 || ya !== 4'h5 || ivld !== 1'b0) begin
      errors++;
      $display("FAIL redir_r1: x=%h y=%h v=%b want x=3 y=5 v=0", xa, ya, ivld);
    end
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    checks++;
    if (ivld !== 1'b1 || ipc !== 8'h35 || instr !== 32'h305) begin
      errors++;
      $display("FAIL redir_r3: v=%b pc=%h ins=%h want pc=35 ins=305",
               ivld, ipc, instr);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] e;
    step(1, 1, 1, 8'hFE);
    repeat (2) step(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      e = 8'hFE + 8'(i);
      checks++;
      if (ivld !== 1'b1 || ipc !== e || instr !== mem_word(e)) begin
        errors++;
        $display("FAIL wrap_%0d: v=%b pc=%h ins=%h want pc=%h", i, ivld, ipc, instr, e);
      end
    end
  endtask

  task automatic test_fetch_en;
    logic [7:0] h;
    repeat (4) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    h = ipc;
    checks++;
    if (ivld !== 1'b1 || {xa, ya} !== h + 8'd2) begin
      errors++;
      $display("FAIL fe_f0: v=%b xy=%h want xy=%h", ivld, {xa, ya}, h + 8'd2);
    end
    step(0, 1, 0, 0);
    checks++;
    if (ivld !== 1'b1 || ipc !== h + 8'd1 || {xa, ya} !== h + 8'd2) begin
      errors++;
      $display("FAIL fe_f1: v=%b pc=%h xy=%h want pc=%h", ivld, ipc, {xa, ya}, h + 8'd1);
    end
    step(0, 1, 0, 0);
    checks++;
    if (ivld !== 1'b0 || {xa, ya} !== h + 8'd2) begin
      errors++;
      $display("FAIL fe_f2: v=%b xy=%h want v=0 xy=%h", ivld, {xa, ya}, h + 8'd2);
    end
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    checks++;
    if ({xa, ya} !== h + 8'd3) begin
      errors++;
      $display("FAIL fe_f4: xy=%h want %h", {xa, ya}, h + 8'd3);
    end
    step(1, 1, 0, 0);
    checks++;
    if (ivld !== 1'b1 || ipc !== h + 8'd2) begin
      errors++;
      $display("FAIL fe_f5: v=%b pc=%h want %h", ivld, ipc, h + 8'd2);
    end
  endtask

  task automatic test_reset_mid;
    repeat (4) step(1, 1, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ivld !== 1'b0 || ipc !== 8'h00 || instr !== 32'h0 || {xa, ya} !== 8'h00) begin
      errors++;
      $display("FAIL async_rst: v=%b pc=%h ins=%h xy=%h want all 0",
               ivld, ipc, instr, {xa, ya});
    end
    repeat (2) @(negedge clk);
    release_stream();
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 8) != 0, ($urandom % 4) != 0,
           ($urandom % 20) == 0, 8'($urandom));
    end
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_fetch_en();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
